rom_download_router: RTL and testbench

- Sits between data_io and the per-core memories in arcade tops.
- Steers the ioctl byte stream into either an on-chip BRAM window (byte writes) or SDRAM.
- SDRAM writes are packed into WB-byte words with lane strobes and issued over the toggle req/ack handshake used by the sdram controller.
- Generates the rom_loaded flag and the core reset. It is the parametrised successor of the ad-hoc per-core upload glue: configurable word width, index filtering, a BRAM window, back-pressure buffering and overflow detection.

---
 rtl/rom_download_router.sv | 216 +++++++++++++++++++++
 tb/tb_rom_download_router.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_download_router.sv
// Steers the ioctl download byte stream into a BRAM window or, packed into WB-byte words, into
// SDRAM over a toggle req/ack handshake; also produces rom_loaded and the core reset.
module rom_download_router #(
   parameter int unsigned WB         = 2,
   parameter int unsigned AW         = 23,
   parameter logic [7:0]  ROM_INDEX  = 8'd0,
   parameter logic [24:0] BRAM_BASE  = 25'h0C000,
   parameter int unsigned BRAM_AW    = 14,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic               clk_sys,
   input  logic               reset,
   input  logic               ioctl_download,
   input  logic [7:0]         ioctl_index,
   input  logic               ioctl_wr,
   input  logic [24:0]        ioctl_addr,
   input  logic [7:0]         ioctl_dout,
   input  logic               user_reset,
   output logic               sdram_req,
   input  logic               sdram_ack,
   output logic               sdram_we,
   output logic [AW-1:0]      sdram_addr,
   output logic [8*WB-1:0]    sdram_d,
   output logic [WB-1:0]      sdram_ds,
   output logic               dl_we,
   output logic [BRAM_AW-1:0] dl_addr,
   output logic [7:0]         dl_data,
   output logic               rom_loaded,
   output logic               core_reset,
   output logic               overflow
);
   localparam int unsigned DW = 8 * WB;
   localparam int unsigned LW = $clog2(WB);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam logic [25:0] BRAM_END = {1'b0, BRAM_BASE} + (26'd1 << BRAM_AW);

   typedef enum logic {StIdle, StWait} state_e;

   logic              wr_q, wr_qq, dl_q, dl_qq, ack_s1_q, ack_s2_q;
   logic [24:0]       addr_q;
   logic [7:0]        data_q;
   state_e            state_q, state_d;
   logic              sdram_req_q, sdram_req_d, sdram_we_q, sdram_we_d;
   logic [AW-1:0]     sdram_addr_q, sdram_addr_d;
   logic [DW-1:0]     sdram_d_q, sdram_d_d;
   logic [WB-1:0]     sdram_ds_q, sdram_ds_d;
   logic              dl_we_q, dl_we_d;
   logic [BRAM_AW-1:0] dl_addr_q, dl_addr_d;
   logic [7:0]        dl_data_q, dl_data_d;
   logic              rom_loaded_q, rom_loaded_d, pending_q, pending_d;
   logic              core_reset_q, core_reset_d, overflow_q, overflow_d;
   logic              pv_q, pv_d, pfull_q, pfull_d;
   logic [AW-1:0]     pa_q, pa_d;
   logic [DW-1:0]     pd_q, pd_d;
   logic [WB-1:0]     pds_q, pds_d;
   logic [PW:0]       wp_q, wp_d, rp_q, rp_d;
   logic [AW-1:0]     fa_mem [FIFO_DEPTH];
   logic [DW-1:0]     fd_mem [FIFO_DEPTH];
   logic [WB-1:0]     fds_mem [FIFO_DEPTH];

   logic          byte_ev, start_ev, end_ev, bram_hit, fifo_empty, fifo_full;
   logic          push, push_ok, pop, idle;
   logic [1:0]    lane;
   logic [4:0]    lane_sh;
   logic [AW-1:0] word_addr, push_a;
   logic [DW-1:0] push_d;
   logic [WB-1:0] push_ds;

   assign byte_ev   = wr_q & ~wr_qq & dl_q;
   assign start_ev  = dl_q & ~dl_qq;
   assign end_ev    = ~dl_q & dl_qq;
   assign bram_hit  = ({1'b0, addr_q} >= {1'b0, BRAM_BASE}) && ({1'b0, addr_q} < BRAM_END);
   assign lane      = addr_q[1:0] & 2'(WB - 1);
   assign lane_sh   = {lane, 3'b000};
   assign word_addr = AW'(32'(addr_q) >> LW);

   assign fifo_empty = (wp_q == rp_q);
   assign fifo_full  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
   assign idle       = (state_q == StIdle);
   assign pop        = idle && !fifo_empty;
   assign push_ok    = push && (!fifo_full || pop);

   // Pack register; a flush and a completing byte in one cycle park the new word in pfull.
   always_comb begin
      pv_d    = pv_q;
      pfull_d = pfull_q;
      pa_d    = pa_q;
      pd_d    = pd_q;
      pds_d   = pds_q;
      push    = 1'b0;
      push_a  = pa_q;
      push_d  = pd_q;
      push_ds = pds_q;
      if (start_ev) begin
         pv_d = 1'b0; pfull_d = 1'b0; pd_d = '0; pds_d = '0;
      end else if (pfull_q || (end_ev && pv_q)) begin
         push = 1'b1; pv_d = 1'b0; pfull_d = 1'b0; pd_d = '0; pds_d = '0;
      end
      if (byte_ev && !bram_hit) begin
         if (pv_d && (pa_d != word_addr)) begin
            push = 1'b1; pv_d = 1'b0; pd_d = '0; pds_d = '0;
         end
         if (!pv_d) pa_d = word_addr;
         pv_d  = 1'b1;
         pd_d  = (pd_d & ~(DW'(8'hFF) << lane_sh)) | (DW'(data_q) << lane_sh);
         pds_d = pds_d | (WB'(1) << lane);
         if (lane == 2'(WB - 1)) begin
            if (push) begin
               pfull_d = 1'b1;
            end else begin
               push = 1'b1; push_a = pa_d; push_d = pd_d; push_ds = pds_d;
               pv_d = 1'b0; pd_d = '0; pds_d = '0;
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      sdram_req_d  = sdram_req_q;
      sdram_we_d   = sdram_we_q;
      sdram_addr_d = sdram_addr_q;
      sdram_d_d    = sdram_d_q;
      sdram_ds_d   = sdram_ds_q;
      case (state_q)
         StIdle: if (!fifo_empty) begin
            sdram_addr_d = fa_mem[rp_q[PW-1:0]];
            sdram_d_d    = fd_mem[rp_q[PW-1:0]];
            sdram_ds_d   = fds_mem[rp_q[PW-1:0]];
            sdram_we_d   = 1'b1;
            sdram_req_d  = ~sdram_req_q;
            state_d      = StWait;
         end
         StWait: if (ack_s2_q == sdram_req_q) begin
            sdram_we_d = 1'b0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      wp_d         = wp_q + (PW+1)'(push_ok);
      rp_d         = rp_q + (PW+1)'(pop);
      overflow_d   = overflow_q;
      rom_loaded_d = rom_loaded_q;
      pending_d    = pending_q;
      dl_we_d      = byte_ev && bram_hit;
      dl_addr_d    = dl_addr_q;
      dl_data_d    = dl_data_q;
      if (start_ev) overflow_d = 1'b0;
      if (push && !push_ok) overflow_d = 1'b1;
      if (start_ev) begin
         rom_loaded_d = 1'b0;
         pending_d    = 1'b0;
      end else if (end_ev) begin
         pending_d = 1'b1;
      end else if (pending_q && !pv_q && !pfull_q && fifo_empty && idle && !push) begin
         rom_loaded_d = 1'b1;
         pending_d    = 1'b0;
      end
      if (dl_we_d) begin
         dl_addr_d = BRAM_AW'(addr_q - BRAM_BASE);
         dl_data_d = data_q;
      end
      core_reset_d = user_reset | ~rom_loaded_q | dl_q | ~(fifo_empty & idle);
   end

   always_ff @(posedge clk_sys) begin
      if (push_ok) begin
         fa_mem[wp_q[PW-1:0]]  <= push_a;
         fd_mem[wp_q[PW-1:0]]  <= push_d;
         fds_mem[wp_q[PW-1:0]] <= push_ds;
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_q <= 1'b0; wr_qq <= 1'b0; dl_q <= 1'b0; dl_qq <= 1'b0;
         ack_s1_q <= 1'b0; ack_s2_q <= 1'b0;
         addr_q <= '0; data_q <= '0;
         state_q <= StIdle;
         sdram_req_q <= 1'b0; sdram_we_q <= 1'b0;
         sdram_addr_q <= '0; sdram_d_q <= '0; sdram_ds_q <= '0;
         dl_we_q <= 1'b0; dl_addr_q <= '0; dl_data_q <= '0;
         rom_loaded_q <= 1'b0; pending_q <= 1'b0; core_reset_q <= 1'b1; overflow_q <= 1'b0;
         pv_q <= 1'b0; pfull_q <= 1'b0; pa_q <= '0; pd_q <= '0; pds_q <= '0;
         wp_q <= '0; rp_q <= '0;
      end else begin
         wr_q <= ioctl_wr; wr_qq <= wr_q;
         dl_q <= ioctl_download && (ioctl_index == ROM_INDEX); dl_qq <= dl_q;
         ack_s1_q <= sdram_ack; ack_s2_q <= ack_s1_q;
         addr_q <= ioctl_addr; data_q <= ioctl_dout;
         state_q <= state_d;
         sdram_req_q <= sdram_req_d; sdram_we_q <= sdram_we_d;
         sdram_addr_q <= sdram_addr_d; sdram_d_q <= sdram_d_d; sdram_ds_q <= sdram_ds_d;
         dl_we_q <= dl_we_d; dl_addr_q <= dl_addr_d; dl_data_q <= dl_data_d;
         rom_loaded_q <= rom_loaded_d; pending_q <= pending_d;
         core_reset_q <= core_reset_d; overflow_q <= overflow_d;
         pv_q <= pv_d; pfull_q <= pfull_d; pa_q <= pa_d; pd_q <= pd_d; pds_q <= pds_d;
         wp_q <= wp_d; rp_q <= rp_d;
      end
   end

   assign sdram_req  = sdram_req_q;
   assign sdram_we   = sdram_we_q;
   assign sdram_addr = sdram_addr_q;
   assign sdram_d    = sdram_d_q;
   assign sdram_ds   = sdram_ds_q;
   assign dl_we      = dl_we_q;
   assign dl_addr    = dl_addr_q;
   assign dl_data    = dl_data_q;
   assign rom_loaded = rom_loaded_q;
   assign core_reset = core_reset_q;
   assign overflow   = overflow_q;
endmodule

// File: tb/tb_rom_download_router.sv
// Bench for rom_download_router (WB=2, depth 2): table vectors, directed corner sequences and
// random downloads checked against a byte-list reference model.
module tb_rom_download_router;
   logic        clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
   logic        user_reset = 1'b0, sdram_ack = 1'b0;
   logic [7:0]  ioctl_index = 8'd0, ioctl_dout = 8'd0;
   logic [24:0] ioctl_addr = 25'd0;
   logic        sdram_req, sdram_we, dl_we, rom_loaded, core_reset, overflow;
   logic [22:0] sdram_addr;
   logic [15:0] sdram_d;
   logic [1:0]  sdram_ds;
   logic [13:0] dl_addr;
   logic [7:0]  dl_data;

   rom_download_router #(
      .WB(2), .AW(23), .ROM_INDEX(8'd0), .BRAM_BASE(25'h0C000), .BRAM_AW(14), .FIFO_DEPTH(2)
   ) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .user_reset(user_reset), .sdram_req(sdram_req),
      .sdram_ack(sdram_ack), .sdram_we(sdram_we), .sdram_addr(sdram_addr), .sdram_d(sdram_d),
      .sdram_ds(sdram_ds), .dl_we(dl_we), .dl_addr(dl_addr), .dl_data(dl_data),
      .rom_loaded(rom_loaded), .core_reset(core_reset), .overflow(overflow)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct packed {logic [22:0] a; logic [15:0] d; logic [1:0] ds;} word_t;
   typedef struct packed {logic [13:0] a; logic [7:0] d;} bbyte_t;
   typedef struct {
      logic [7:0] idx; logic [24:0] a; logic [7:0] d;
      bit e_dl; logic [13:0] e_dla; bit e_sd; word_t e_w;
   } vec_t;

   word_t       got_w[$], exp_w[$];
   bbyte_t      got_b[$], exp_b[$];
   logic [24:0] st_a[$];
   logic [7:0]  st_d[$];
   int total = 0, bad = 0, cyc = 0, ack_lat = 1, ack_cyc = 0;
   bit ack_en = 1'b1;
   logic last_req = 1'b0, last_dlwe = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Records every issued request and every BRAM write pulse.
   initial begin : mon
      forever begin
         @(negedge clk_sys);
         cyc++;
         if (reset) begin
            last_req = 1'b0; last_dlwe = 1'b0;
         end else begin
            if (sdram_req != last_req) begin
               got_w.push_back(word_t'({sdram_addr, sdram_d, sdram_ds}));
               chk("we_with_req", 64'(sdram_we), 64'd1);
               last_req = sdram_req;
            end
            if (dl_we) begin
               got_b.push_back(bbyte_t'({dl_addr, dl_data}));
               chk("dl_we_width", 64'(last_dlwe), 64'd0);
            end
            last_dlwe = dl_we;
         end
      end
   end

   // SDRAM controller stand-in: answers a pending toggle after ack_lat cycles.
   initial begin : ack_model
      int cnt;
      cnt = 0;
      forever begin
         @(negedge clk_sys);
         if (reset) begin
            sdram_ack = 1'b0; cnt = 0;
         end else if (ack_en && (sdram_req != sdram_ack)) begin
            if (cnt >= ack_lat) begin
               sdram_ack = sdram_req; cnt = 0; ack_cyc = cyc;
            end else cnt++;
         end
      end
   end

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: got timeout want finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      tick(3);
      ioctl_wr = 1'b0;
      tick(5);
   endtask

   task automatic dl_begin(input logic [7:0] idx);
      ioctl_index = idx; ioctl_download = 1'b1;
      tick(3);
   endtask

   task automatic dl_end();
      tick(2);
      ioctl_download = 1'b0;
   endtask

   task automatic wait_loaded(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (rom_loaded) break;
         tick(1);
      end
      chk(name, 64'(rom_loaded), 64'd1);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_sdram"}, 64'({sdram_req, sdram_we, sdram_addr, sdram_d, sdram_ds}), 64'd0);
      chk({tag, "_misc"}, 64'({dl_we, dl_addr, dl_data, rom_loaded, core_reset, overflow}),
          64'd2);
   endtask

   task automatic gen_stim(input int n);
      logic [24:0] a;
      a = 25'($urandom_range(0, 40));
      st_a.delete(); st_d.delete();
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 5))
            0, 1, 2: a = a + 25'd1;
            3:       a = 25'($urandom_range(0, 63));
            default: a = 25'h0C000 + 25'($urandom_range(0, 15));
         endcase
         st_a.push_back(a);
         st_d.push_back(8'($urandom));
      end
   endtask

   // Expected SDRAM words and BRAM bytes derived directly from the byte list.
   task automatic build_expect();
      bit pv;
      logic [22:0] pa, wa;
      logic [15:0] pd;
      logic [1:0]  pds;
      int lane;
      exp_w.delete(); exp_b.delete();
      pv = 1'b0; pa = '0; pd = '0; pds = '0;
      foreach (st_a[i]) begin
         if (st_a[i] >= 25'h0C000 && st_a[i] < 25'h10000) begin
            exp_b.push_back(bbyte_t'({14'(st_a[i] - 25'h0C000), st_d[i]}));
         end else begin
            wa = 23'(st_a[i] >> 1);
            lane = st_a[i][0] ? 1 : 0;
            if (pv && wa != pa) begin exp_w.push_back(word_t'({pa, pd, pds})); pv = 1'b0; end
            if (!pv) begin pa = wa; pd = '0; pds = '0; pv = 1'b1; end
            pd[lane*8 +: 8] = st_d[i];
            pds[lane] = 1'b1;
            if (lane == 1) begin exp_w.push_back(word_t'({pa, pd, pds})); pv = 1'b0; end
         end
      end
      if (pv) exp_w.push_back(word_t'({pa, pd, pds}));
   endtask

   task automatic compare_results(input string tag);
      chk({tag, "_nwords"}, 64'(got_w.size()), 64'(exp_w.size()));
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++)
         chk({tag, "_word"}, 64'(got_w[i]), 64'(exp_w[i]));
      chk({tag, "_nbram"}, 64'(got_b.size()), 64'(exp_b.size()));
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
         chk({tag, "_bram"}, 64'(got_b[i]), 64'(exp_b[i]));
   endtask

   task automatic random_download(input string tag);
      gen_stim(12);
      build_expect();
      got_w.delete(); got_b.delete();
      dl_begin(8'd0);
      foreach (st_a[i]) send_byte(st_a[i], st_d[i]);
      dl_end();
      wait_loaded({tag, "_loaded"}, 400);
      compare_results(tag);
   endtask

   vec_t vt[9];
   logic was_loaded;
   int   loaded_at;

   initial begin : main
      vt[0] = '{8'd0, 25'h0000000, 8'h11, 1'b0, 14'h0,    1'b1, word_t'({23'h0, 16'h0011, 2'b01})};
      vt[1] = '{8'd0, 25'h000C010, 8'h3C, 1'b1, 14'h010,  1'b0, word_t'(41'd0)};
      vt[2] = '{8'd1, 25'h0000002, 8'h77, 1'b0, 14'h0,    1'b0, word_t'(41'd0)};
      vt[3] = '{8'd0, 25'h000BFFF, 8'h5A, 1'b0, 14'h0,    1'b1, word_t'({23'h5FFF, 16'h5A00, 2'b10})};
      vt[4] = '{8'd0, 25'h000C000, 8'hA5, 1'b1, 14'h0000, 1'b0, word_t'(41'd0)};
      vt[5] = '{8'd0, 25'h000FFFF, 8'hC3, 1'b1, 14'h3FFF, 1'b0, word_t'(41'd0)};
      vt[6] = '{8'd0, 25'h0010000, 8'hE7, 1'b0, 14'h0,    1'b1, word_t'({23'h8000, 16'h00E7, 2'b01})};
      vt[7] = '{8'd0, 25'h1000005, 8'h99, 1'b0, 14'h0,    1'b1, word_t'({23'h2, 16'h9900, 2'b10})};
      vt[8] = '{8'd1, 25'h000C020, 8'h44, 1'b0, 14'h0,    1'b0, word_t'(41'd0)};

      // Reset state
      tick(3);
      check_reset_vals("rst");
      reset = 1'b0;
      tick(2);
      check_reset_vals("post_rst");

      // Full word AA@0, BB@1
      ack_lat = 2;
      got_w.delete(); got_b.delete();
      dl_begin(8'd0);
      send_byte(25'd0, 8'hAA);
      send_byte(25'd1, 8'hBB);
      dl_end();
      wait_loaded("full_loaded", 200);
      chk("full_nwords", 64'(got_w.size()), 64'd1);
      if (got_w.size() > 0) chk("full_word", 64'(got_w[0]), 64'({23'd0, 16'hBBAA, 2'b11}));
      chk("full_req", 64'(sdram_req), 64'd1);
      chk("full_we_after_ack", 64'(sdram_we), 64'd0);

      // Partial word flushed by download end; rom_loaded only after ack
      ack_lat = 6;
      got_w.delete();
      dl_begin(8'd0);
      send_byte(25'd5, 8'h55);
      dl_end();
      loaded_at = -1;
      for (int i = 0; i < 200; i++) begin
         if (rom_loaded) begin loaded_at = cyc; break; end
         tick(1);
      end
      chk("part_loaded", 64'(rom_loaded), 64'd1);
      chk("part_loaded_after_ack", 64'(loaded_at > ack_cyc), 64'd1);
      chk("part_core_reset_at_load", 64'(core_reset), 64'd1);
      tick(1);
      chk("part_core_reset_next", 64'(core_reset), 64'd0);
      chk("part_nwords", 64'(got_w.size()), 64'd1);
      if (got_w.size() > 0) chk("part_word", 64'(got_w[0]), 64'({23'd2, 16'h5500, 2'b10}));

      // Single-byte table vectors
      ack_lat = 1;
      for (int i = 0; i < 9; i++) begin
         was_loaded = rom_loaded;
         got_w.delete(); got_b.delete();
         dl_begin(vt[i].idx);
         send_byte(vt[i].a, vt[i].d);
         dl_end();
         if (vt[i].idx == 8'd0) begin
            wait_loaded("vec_loaded", 200);
         end else begin
            tick(40);
            chk("vec_idx_loaded", 64'(rom_loaded), 64'(was_loaded));
         end
         chk("vec_nreq", 64'(got_w.size()), 64'(vt[i].e_sd));
         chk("vec_ndl", 64'(got_b.size()), 64'(vt[i].e_dl));
         if (vt[i].e_sd && got_w.size() > 0) chk("vec_word", 64'(got_w[0]), 64'(vt[i].e_w));
         if (vt[i].e_dl && got_b.size() > 0)
            chk("vec_dl", 64'(got_b[0]), 64'({vt[i].e_dla, vt[i].d}));
      end

      // user_reset forces core_reset
      user_reset = 1'b1;
      tick(2);
      chk("user_reset_on", 64'(core_reset), 64'd1);
      user_reset = 1'b0;
      tick(2);
      chk("user_reset_off", 64'(core_reset), 64'd0);

      // Overflow with ack held
      ack_en = 1'b0;
      got_w.delete(); got_b.delete();
      dl_begin(8'd0);
      for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(8'h10 + i));
      tick(4);
      chk("ovf_set", 64'(overflow), 64'd1);
      dl_end();
      tick(20);
      chk("ovf_not_loaded", 64'(rom_loaded), 64'd0);
      chk("ovf_core_reset", 64'(core_reset), 64'd1);
      ack_en = 1'b1;
      wait_loaded("ovf_loaded", 300);
      chk("ovf_nwords", 64'(got_w.size()), 64'd3);
      for (int i = 0; i < 3 && i < got_w.size(); i++)
         chk("ovf_word", 64'(got_w[i]),
             64'({23'(i), 8'(8'h11 + 2 * i), 8'(8'h10 + 2 * i), 2'b11}));
      chk("ovf_sticky", 64'(overflow), 64'd1);
      dl_begin(8'd0);
      chk("ovf_cleared", 64'(overflow), 64'd0);
      dl_end();
      wait_loaded("ovf_clear_loaded", 200);

      // Random downloads
      for (int k = 0; k < 4; k++) begin
         ack_lat = $urandom_range(0, 1);
         random_download("rand");
         chk("rand_no_ovf", 64'(overflow), 64'd0);
      end

      // Reset mid-word, then a full download
      ack_lat = 1;
      got_w.delete(); got_b.delete();
      dl_begin(8'd0);
      send_byte(25'h20, 8'h66);
      reset = 1'b1;
      ioctl_download = 1'b0;
      tick(1);
      check_reset_vals("midrst");
      reset = 1'b0;
      tick(20);
      chk("midrst_no_req", 64'(got_w.size()), 64'd0);
      chk("midrst_not_loaded", 64'(rom_loaded), 64'd0);
      random_download("after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
